// File: rtl/rv32i_inst_encoder_if.sv
// Request/response bundle for the RV32I instruction encoder.
// The master issues symbolic instructions and consumes encoded words; the slave is the encoder.
interface rv32i_inst_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_addr;
    logic        err_pulse;
    logic        err_sticky;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_inst, out_addr, err_pulse, err_sticky
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_inst, out_addr, err_pulse, err_sticky
    );
endinterface

// File: rtl/rv32i_inst_encoder.sv
// Streaming RV32I encoder: symbolic instruction in, packed 32-bit word plus address out.
// LI is expanded to LUI+ADDI; out-of-range or illegal requests are consumed and flagged.
module rv32i_inst_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ADDR_STEP = 32'd4
) (
    input logic                 clk,
    input logic                 rst_n,
    rv32i_inst_encoder_if.slave bus
);
    typedef enum logic {IDLE, LI2} state_t;

    state_t      state_q, state_d;
    logic        accept, out_hs;
    logic        legal, li_two;
    logic [31:0] enc, li_word, pend_q;
    logic [19:0] lui_hi;
    logic        fits12, fits13, fits21;

    function automatic logic [2:0] f3_of(input logic [5:0] op);
        case (op)
            6'd5, 6'd11, 6'd16, 6'd24, 6'd29:           f3_of = 3'd1;
            6'd12, 6'd17, 6'd19, 6'd30:                 f3_of = 3'd2;
            6'd20, 6'd31:                               f3_of = 3'd3;
            6'd6, 6'd13, 6'd21, 6'd32:                  f3_of = 3'd4;
            6'd7, 6'd14, 6'd25, 6'd26, 6'd33, 6'd34:    f3_of = 3'd5;
            6'd8, 6'd22, 6'd35:                         f3_of = 3'd6;
            6'd9, 6'd23, 6'd36:                         f3_of = 3'd7;
            default:                                    f3_of = 3'd0;
        endcase
    endfunction

    assign bus.in_ready = (state_q == IDLE) && (!bus.out_valid || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign out_hs       = bus.out_valid && bus.out_ready;

    // Sign-fit tests: all bits above the signed field width must equal its sign bit.
    assign fits12 = (bus.in_imm[31:11] == '0) || (bus.in_imm[31:11] == '1);
    assign fits13 = (bus.in_imm[31:12] == '0) || (bus.in_imm[31:12] == '1);
    assign fits21 = (bus.in_imm[31:20] == '0) || (bus.in_imm[31:20] == '1);
    // (imm + 0x800) >> 12 reduces to the upper field plus the carry out of bit 11.
    assign lui_hi = bus.in_imm[31:12] + {19'd0, bus.in_imm[11]};

    always_comb begin
        enc     = '0;
        legal   = 1'b1;
        li_two  = 1'b0;
        li_word = {bus.in_imm[11:0], bus.in_rd, 3'b000, bus.in_rd, 7'b0010011};
        case (bus.in_op) inside
            6'd0, 6'd1: begin
                legal = (bus.in_imm[31:20] == '0);
                enc   = {bus.in_imm[19:0], bus.in_rd, (bus.in_op == 6'd0) ? 7'b0110111 : 7'b0010111};
            end
            6'd2: begin
                legal = fits21 && !bus.in_imm[0];
                enc   = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11], bus.in_imm[19:12],
                         bus.in_rd, 7'b1101111};
            end
            6'd3: begin
                legal = fits12;
                enc   = {bus.in_imm[11:0], bus.in_rs1, 3'b000, bus.in_rd, 7'b1100111};
            end
            [6'd4:6'd9]: begin
                legal = fits13 && !bus.in_imm[0];
                enc   = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, f3_of(bus.in_op),
                         bus.in_imm[4:1], bus.in_imm[11], 7'b1100011};
            end
            [6'd10:6'd14]: begin
                legal = fits12;
                enc   = {bus.in_imm[11:0], bus.in_rs1, f3_of(bus.in_op), bus.in_rd, 7'b0000011};
            end
            [6'd15:6'd17]: begin
                legal = fits12;
                enc   = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, f3_of(bus.in_op),
                         bus.in_imm[4:0], 7'b0100011};
            end
            [6'd18:6'd23]: begin
                legal = fits12;
                enc   = {bus.in_imm[11:0], bus.in_rs1, f3_of(bus.in_op), bus.in_rd, 7'b0010011};
            end
            [6'd24:6'd26]: begin
                legal = (bus.in_imm[31:5] == '0);
                enc   = {(bus.in_op == 6'd26) ? 7'h20 : 7'h00, bus.in_imm[4:0], bus.in_rs1,
                         f3_of(bus.in_op), bus.in_rd, 7'b0010011};
            end
            [6'd27:6'd36]: begin
                enc = {(bus.in_op == 6'd28 || bus.in_op == 6'd34) ? 7'h20 : 7'h00, bus.in_rs2,
                       bus.in_rs1, f3_of(bus.in_op), bus.in_rd, 7'b0110011};
            end
            6'd37: begin
                legal = (bus.in_imm[31:8] == '0);
                enc   = {4'h0, bus.in_imm[7:0], 5'd0, 3'b000, 5'd0, 7'b0001111};
            end
            6'd38: enc = 32'h0000_100F;
            6'd39: enc = 32'h0000_0073;
            6'd40: enc = 32'h0010_0073;
            6'd41: begin
                if (fits12) begin
                    enc = {bus.in_imm[11:0], 5'd0, 3'b000, bus.in_rd, 7'b0010011};
                end else begin
                    enc    = {lui_hi, bus.in_rd, 7'b0110111};
                    li_two = (bus.in_imm[11:0] != '0);
                end
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && legal && li_two) state_d = LI2;
            LI2:  if (out_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid  <= 1'b0;
            bus.out_inst   <= '0;
            bus.out_addr   <= BASE_ADDR;
            bus.err_pulse  <= 1'b0;
            bus.err_sticky <= 1'b0;
            pend_q         <= '0;
        end else begin
            bus.err_pulse <= accept && !legal;
            if (accept && !legal) bus.err_sticky <= 1'b1;
            if (out_hs) bus.out_addr <= bus.out_addr + ADDR_STEP;

            if (state_q == LI2 && out_hs) begin
                bus.out_inst <= pend_q;
            end else if (accept && legal) begin
                bus.out_valid <= 1'b1;
                bus.out_inst  <= enc;
                if (li_two) pend_q <= li_word;
            end else if (out_hs) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule
